// File: rtl/risp_pkg.sv
// Shared RISP types and sizing/saturation helpers
// used by the neuron and synapse blocks.
package risp_pkg;

    localparam int CHARGE_W = 8;
    localparam int POT_W    = 16;

    typedef logic signed [CHARGE_W-1:0] charge_t;
    typedef logic signed [POT_W-1:0]    potential_t;

    function automatic int sum_width(
        input int pot_w,
        input int chg_w,
        input int n
    );
        return ((pot_w > chg_w) ? pot_w : chg_w) + $clog2(n + 1) + 1;
    endfunction

    // Floor at min, saturate at the most positive value of pot_w bits
    function automatic longint sat_clamp(
        input longint sum,
        input longint min,
        input int     pot_w
    );
        longint max_v;
        max_v = (longint'(1) <<< (pot_w - 1)) - longint'(1);
        if (sum < min)
            return min;
        if (sum > max_v)
            return max_v;
        return sum;
    endfunction

endpackage

// File: rtl/risp_charge_sum.sv
// Combinational sign-extending adder of all synapse
// charges onto a base potential.
module risp_charge_sum
    import risp_pkg::*;
#(
    parameter int NUM_INP      = 1,
    parameter int CHARGE_WIDTH = 8,
    parameter int SUM_W        = 18
) (
    input  logic signed [CHARGE_WIDTH-1:0] i_inp [NUM_INP],
    input  logic signed [SUM_W-1:0]        i_base,
    output logic signed [SUM_W-1:0]        o_sum
);

    localparam int EXT_W = SUM_W - CHARGE_WIDTH;

    always_comb begin
        o_sum = i_base;
        for (int i = 0; i < NUM_INP; i++) begin
            o_sum = o_sum
                  + {{EXT_W{i_inp[i][CHARGE_WIDTH-1]}}, i_inp[i]};
        end
    end

endmodule

// File: rtl/risp_neuron.sv
// RISP integrate-and-fire neuron with optional leak,
// potential floor and refractory period.
module risp_neuron
    import risp_pkg::*;
#(
    parameter int NUM_INP          = 1,
    parameter int CHARGE_WIDTH     = 8,
    parameter int POTENTIAL_WIDTH  = 16,
    parameter int THRESHOLD        = 1,
    parameter int MIN_POTENTIAL    = 0,
    parameter int LEAK             = 0,
    parameter int REFRACTORY       = 0,
    parameter int FIRE_LIKE_RAVENS = 0
) (
    input  logic                              clk,
    input  logic                              arstn,
    input  logic                              en,
    input  logic signed [CHARGE_WIDTH-1:0]    inp [NUM_INP],
    output logic                              out,
    output logic signed [POTENTIAL_WIDTH-1:0] potential
);

    localparam int SUM_W = sum_width(POTENTIAL_WIDTH, CHARGE_WIDTH, NUM_INP);
    localparam int RW    = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
    localparam int PEXT  = SUM_W - POTENTIAL_WIDTH;

    logic signed [POTENTIAL_WIDTH-1:0] r_pot;
    logic                              r_fire;
    logic [RW-1:0]                     r_refr;

    logic signed [SUM_W-1:0]           w_base;
    logic signed [SUM_W-1:0]           w_sum;
    logic signed [POTENTIAL_WIDTH-1:0] w_clamp;
    logic                              w_refr;
    logic                              w_fire;

    assign w_base = (LEAK != 0) ? '0
                  : {{PEXT{r_pot[POTENTIAL_WIDTH-1]}}, r_pot};

    risp_charge_sum #(
        .NUM_INP      (NUM_INP),
        .CHARGE_WIDTH (CHARGE_WIDTH),
        .SUM_W        (SUM_W)
    ) u_sum (
        .i_inp  (inp),
        .i_base (w_base),
        .o_sum  (w_sum)
    );

    // Compare and clamp in 64 bits so any THRESHOLD/floor fits
    assign w_refr  = (r_refr != '0);
    assign w_fire  = en && !w_refr
                   && (longint'(w_sum) >= longint'(THRESHOLD));
    assign w_clamp = POTENTIAL_WIDTH'(sat_clamp(longint'(w_sum),
                                                longint'(MIN_POTENTIAL),
                                                POTENTIAL_WIDTH));

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_pot  <= '0;
            r_fire <= 1'b0;
            r_refr <= '0;
        end else if (en) begin
            r_fire <= w_fire;
            unique case (1'b1)
                w_refr: begin
                    r_refr <= r_refr - RW'(1);
                    r_pot  <= '0;
                end
                w_fire: begin
                    r_refr <= RW'(REFRACTORY);
                    r_pot  <= '0;
                end
                default: r_pot <= w_clamp;
            endcase
        end
    end

    assign out       = (FIRE_LIKE_RAVENS != 0) ? w_fire : r_fire;
    assign potential = r_pot;

endmodule

// File: tb/tb_risp_neuron.sv
// Directed scoreboard bench over several risp_neuron
// configurations sharing clock, enable and reset.
module tb_risp_neuron;

    localparam int A = 0;
    localparam int L = 1;
    localparam int M = 2;
    localparam int R = 3;
    localparam int S = 4;
    localparam int H = 5;

    logic clk;
    logic arstn;
    logic en;

    logic signed [7:0] inp_a [1];
    logic signed [7:0] inp_l [1];
    logic signed [7:0] inp_m [1];
    logic signed [7:0] inp_r [1];
    logic signed [7:0] inp_s [3];
    logic signed [7:0] inp_h [3];

    logic out_a, out_l, out_m, out_r, out_s, out_h;
    logic signed [15:0] pot_a, pot_l, pot_m, pot_r;
    logic signed [7:0]  pot_s, pot_h;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string tag;
        int    id;
        logic  out;
        int    pot;
    } exp_t;

    exp_t q[$];

    risp_neuron #(.THRESHOLD(5)) u_a (
        .clk(clk), .arstn(arstn), .en(en), .inp(inp_a),
        .out(out_a), .potential(pot_a));

    risp_neuron #(.THRESHOLD(5), .LEAK(1)) u_l (
        .clk(clk), .arstn(arstn), .en(en), .inp(inp_l),
        .out(out_l), .potential(pot_l));

    risp_neuron #(.THRESHOLD(5), .MIN_POTENTIAL(-4)) u_m (
        .clk(clk), .arstn(arstn), .en(en), .inp(inp_m),
        .out(out_m), .potential(pot_m));

    risp_neuron #(.THRESHOLD(5), .REFRACTORY(2)) u_r (
        .clk(clk), .arstn(arstn), .en(en), .inp(inp_r),
        .out(out_r), .potential(pot_r));

    risp_neuron #(.NUM_INP(3), .CHARGE_WIDTH(8), .POTENTIAL_WIDTH(8),
                  .THRESHOLD(127), .FIRE_LIKE_RAVENS(1)) u_s (
        .clk(clk), .arstn(arstn), .en(en), .inp(inp_s),
        .out(out_s), .potential(pot_s));

    risp_neuron #(.NUM_INP(3), .CHARGE_WIDTH(8), .POTENTIAL_WIDTH(8),
                  .THRESHOLD(1000)) u_h (
        .clk(clk), .arstn(arstn), .en(en), .inp(inp_h),
        .out(out_h), .potential(pot_h));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic obs_out(input int id);
        case (id)
            A: return out_a;
            L: return out_l;
            M: return out_m;
            R: return out_r;
            S: return out_s;
            H: return out_h;
            default: return 1'bx;
        endcase
    endfunction

    function automatic int obs_pot(input int id);
        case (id)
            A: return int'(pot_a);
            L: return int'(pot_l);
            M: return int'(pot_m);
            R: return int'(pot_r);
            S: return int'(pot_s);
            H: return int'(pot_h);
            default: return -99999;
        endcase
    endfunction

    task automatic expect_(input string tag, input int id,
                           input logic o, input int p);
        exp_t e;
        e.tag = tag;
        e.id  = id;
        e.out = o;
        e.pot = p;
        q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic o;
        int   p;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs_out(e.id);
            p = obs_pot(e.id);
            total++;
            assert (o === e.out) else begin
                bad++;
                $error("FAIL %s out: got=%0b want=%0b", e.tag, o, e.out);
            end
            total++;
            assert (p === e.pot) else begin
                bad++;
                $error("FAIL %s potential: got=%0d want=%0d", e.tag, p, e.pot);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    initial begin
        arstn = 1'b0;
        en    = 1'b0;
        inp_a[0] = 0; inp_l[0] = 0; inp_m[0] = 0; inp_r[0] = 0;
        for (int i = 0; i < 3; i++) begin
            inp_s[i] = 0;
            inp_h[i] = 0;
        end

        #12;
        for (int id = 0; id < 6; id++)
            expect_($sformatf("reset_%0d", id), id, 1'b0, 0);
        drain();
        arstn = 1'b1;
        #1;
        en = 1'b1;

        // Accumulate to threshold, registered spike
        inp_a[0] = 2;
        expect_("t1_s1", A, 1'b0, 2); step();
        expect_("t1_s2", A, 1'b0, 4); step();
        expect_("t1_s3", A, 1'b1, 0); step();
        inp_a[0] = 0;
        expect_("t1_s4", A, 1'b0, 0); step();

        // Enable low holds potential and spike
        inp_a[0] = 2;
        expect_("t5_int", A, 1'b0, 2); step();
        en = 1'b0;
        inp_a[0] = 7;
        repeat (3) begin
            expect_("t5_hold_pot", A, 1'b0, 2); step();
        end
        en = 1'b1;
        inp_a[0] = 3;
        expect_("t5_fire", A, 1'b1, 0); step();
        en = 1'b0;
        inp_a[0] = 0;
        repeat (3) begin
            expect_("t5_hold_spk", A, 1'b1, 0); step();
        end
        en = 1'b1;
        expect_("t5_after", A, 1'b0, 0); step();

        // Leak: no carry-over between steps
        inp_l[0] = 3;
        repeat (3) begin
            expect_("t2_leak", L, 1'b0, 3); step();
        end
        inp_l[0] = 5;
        expect_("t2_fire", L, 1'b1, 0); step();
        inp_l[0] = 0;
        expect_("t2_after", L, 1'b0, 0); step();

        // Floor clamp then fire
        inp_m[0] = -10;
        expect_("t3_floor", M, 1'b0, -4); step();
        inp_m[0] = 9;
        expect_("t3_fire", M, 1'b1, 0); step();
        inp_m[0] = 0;
        expect_("t3_after", M, 1'b0, 0); step();

        // Refractory: fire on steps 0,3,6
        inp_r[0] = 10;
        for (int k = 0; k < 8; k++) begin
            expect_($sformatf("t4_step%0d", k), R,
                    ((k % 3) == 0) ? 1'b1 : 1'b0, 0);
            step();
        end

        // Async reset while refractory
        #2;
        arstn = 1'b0;
        expect_("t5_rst", R, 1'b0, 0);
        settle();
        arstn = 1'b1;
        expect_("t5_rst_fire", R, 1'b1, 0); step();
        inp_r[0] = 0;
        expect_("t5_rst_after", R, 1'b0, 0); step();

        // Combinational spike, multi-input, threshold boundary
        en = 1'b0;
        for (int i = 0; i < 3; i++) inp_s[i] = 127;
        expect_("t6_en0", S, 1'b0, 0); settle();
        en = 1'b1;
        expect_("t6_comb", S, 1'b1, 0); settle();
        expect_("t6_post", S, 1'b1, 0); step();
        for (int i = 0; i < 3; i++) inp_s[i] = 0;
        expect_("t6_zero", S, 1'b0, 0); settle();
        inp_s[0] = 127;
        expect_("t6_eq_th", S, 1'b1, 0); settle();
        inp_s[0] = 126;
        expect_("t6_below", S, 1'b0, 0); settle();
        expect_("t6_accum", S, 1'b1, 126); step();
        inp_s[0] = 0;
        expect_("t6_hold", S, 1'b0, 126); settle();

        // Saturation at max and floor at zero
        for (int i = 0; i < 3; i++) inp_h[i] = 127;
        expect_("t6_sat1", H, 1'b0, 127); step();
        expect_("t6_sat2", H, 1'b0, 127); step();
        for (int i = 0; i < 3; i++) inp_h[i] = -128;
        expect_("t6_neg", H, 1'b0, 0); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
